// File: rtl/imem_loader_if.sv
// Handshake and instruction-memory bus between the boot loader and its surroundings.
// The master drives the stream and start request; the slave is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, load_len, rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, load_len, rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to
// instruction memory from word 0, checks an XOR checksum and gates core reset.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic           clk_i,
  input logic           rst_ni,
  imem_loader_if.slave  bus_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [7:0]      xsum_q, xsum_d;
  logic            rx_ready_q, im_we_q, cpu_reset_q, busy_q, done_q, err_q;
  logic            xfer;
  logic [ADDR_W:0] addr_inc;

  assign xfer     = bus_if.rx_valid & rx_ready_q;
  assign addr_inc = addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    xsum_d     = xsum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus_if.start) begin
          if (bus_if.load_len > LEN_MAX) begin
            state_d = S_ERROR;
          end else begin
            len_d      = bus_if.load_len;
            addr_d     = '0;
            byte_cnt_d = '0;
            xsum_d     = '0;
            word_d     = '0;
            state_d    = (bus_if.load_len == '0) ? S_CHK : S_RECV;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          word_d     = {word_q[23:0], bus_if.rx_data};
          xsum_d     = xsum_q ^ bus_if.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_inc;
        state_d = (addr_inc == len_q) ? S_CHK : S_RECV;
      end
      S_CHK: begin
        if (xfer) state_d = (bus_if.rx_data == xsum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      xsum_q      <= '0;
      rx_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      xsum_q      <= xsum_d;
      rx_ready_q  <= (state_d == S_RECV) || (state_d == S_CHK);
      im_we_q     <= (state_d == S_WRITE);
      cpu_reset_q <= (state_d != S_DONE);
      busy_q      <= (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHK);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERROR);
    end
  end

  assign bus_if.rx_ready  = rx_ready_q;
  assign bus_if.im_we     = im_we_q;
  assign bus_if.im_addr   = addr_q[ADDR_W-1:0];
  assign bus_if.im_wdata  = word_q;
  assign bus_if.cpu_reset = cpu_reset_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load scenarios plus hand-written
// sequences for reset, length bounds and reset in the middle of a load.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n;

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  len;
    int          nb;
    logic [7:0]  b [10];
    bit          gap;
    bit          exp_done;
    int          exp_nw;
    logic [31:0] w [2];
  } vec_t;

  vec_t tv [7];

  int n_chk = 0;
  int n_err = 0;
  logic [5:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int rdy_viol = 0;

  always @(posedge clk) begin
    if (bus.im_we) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
      if (bus.rx_ready) rdy_viol++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_viol = 0;
  endtask

  task automatic do_start(input logic [6:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.load_len = 7'h7F;
  endtask

  // Present a byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (n < 50 && !ok) begin
      if (bus.rx_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"},  bus.rx_ready, 0);
    chk({tag, "_im_we"},     bus.im_we, 0);
    chk({tag, "_im_addr"},   bus.im_addr, 0);
    chk({tag, "_im_wdata"},  bus.im_wdata, 0);
    chk({tag, "_cpu_reset"}, bus.cpu_reset, 1);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_err"},       bus.err, 0);
  endtask

  task automatic run_vec(input int idx);
    bit ok;
    clear_log();
    do_start(tv[idx].len);
    chk($sformatf("v%0d_busy_after_start", idx), bus.busy, 1);
    for (int i = 0; i < tv[idx].nb; i++) begin
      send_byte(tv[idx].b[i], ok);
      chk($sformatf("v%0d_byte%0d_accepted", idx, i), ok, 1);
      if (tv[idx].gap && (i % 4 != 3)) begin
        bus.rx_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    bus.rx_valid = 1'b0;
    chk($sformatf("v%0d_done", idx), bus.done, tv[idx].exp_done);
    chk($sformatf("v%0d_err", idx), bus.err, !tv[idx].exp_done);
    chk($sformatf("v%0d_cpu_reset", idx), bus.cpu_reset, !tv[idx].exp_done);
    chk($sformatf("v%0d_busy_end", idx), bus.busy, 0);
    chk($sformatf("v%0d_nwrites", idx), wr_addr.size(), tv[idx].exp_nw);
    for (int k = 0; k < tv[idx].exp_nw; k++) begin
      if (k < wr_addr.size()) begin
        chk($sformatf("v%0d_waddr%0d", idx, k), wr_addr[k], k);
        chk($sformatf("v%0d_wdata%0d", idx, k), wr_data[k], tv[idx].w[k]);
      end
    end
    chk($sformatf("v%0d_ready_in_write", idx), rdy_viol, 0);
  endtask

  initial begin
    bit ok;
    logic [7:0]  lb [256];
    logic [7:0]  xs;
    logic [31:0] ew;
    int mism;

    tv[0] = '{7'd2, 9, '{8'h20,8'h08,8'h00,8'h05,8'h20,8'h09,8'h00,8'h0A,8'h0E,8'h00},
              1'b0, 1'b1, 2, '{32'h20080005, 32'h2009000A}};
    tv[1] = '{7'd2, 9, '{8'h20,8'h08,8'h00,8'h05,8'h20,8'h09,8'h00,8'h0A,8'h0F,8'h00},
              1'b0, 1'b0, 2, '{32'h20080005, 32'h2009000A}};
    tv[2] = tv[0];
    tv[3] = '{7'd2, 9, '{8'h20,8'h08,8'h00,8'h05,8'h20,8'h09,8'h00,8'h0A,8'h0E,8'h00},
              1'b1, 1'b1, 2, '{32'h20080005, 32'h2009000A}};
    tv[4] = '{7'd0, 1, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              1'b0, 1'b1, 0, '{32'h0, 32'h0}};
    tv[5] = '{7'd1, 5, '{8'h12,8'h34,8'h56,8'h78,8'h08,8'h00,8'h00,8'h00,8'h00,8'h00},
              1'b1, 1'b1, 1, '{32'h12345678, 32'h0}};
    tv[6] = '{7'd0, 1, '{8'h5A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              1'b0, 1'b0, 0, '{32'h0, 32'h0}};

    // Reset with busy-looking inputs applied.
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.load_len = 7'd2;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAB;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_no_writes", wr_addr.size(), 0);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b1;
    @(posedge clk); #1;
    chk("idle_cpu_reset", bus.cpu_reset, 1);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Oversize length goes straight to ERROR.
    clear_log();
    do_start(7'd65);
    chk("len65_err", bus.err, 1);
    chk("len65_busy", bus.busy, 0);
    chk("len65_cpu_reset", bus.cpu_reset, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("len65_no_writes", wr_addr.size(), 0);

    // Full-depth load.
    clear_log();
    xs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      lb[i] = 8'((i * 7 + 3) & 255);
      xs    = xs ^ lb[i];
    end
    do_start(7'd64);
    for (int i = 0; i < 256; i++) begin
      send_byte(lb[i], ok);
      if (!ok) chk($sformatf("len64_byte%0d_accepted", i), ok, 1);
    end
    send_byte(xs, ok);
    chk("len64_chk_accepted", ok, 1);
    bus.rx_valid = 1'b0;
    chk("len64_nwrites", wr_addr.size(), 64);
    mism = 0;
    for (int k = 0; k < 64; k++) begin
      ew = {lb[4*k], lb[4*k+1], lb[4*k+2], lb[4*k+3]};
      if (k < wr_addr.size()) begin
        if (wr_addr[k] !== 6'(k) || wr_data[k] !== ew) mism++;
      end
    end
    chk("len64_data_mismatches", mism, 0);
    if (wr_addr.size() > 0) chk("len64_last_addr", wr_addr[wr_addr.size()-1], 63);
    chk("len64_done", bus.done, 1);
    chk("len64_err", bus.err, 0);

    // Reset after 5 bytes of a 2-word load, then reload cleanly.
    clear_log();
    do_start(7'd2);
    for (int i = 0; i < 5; i++) begin
      send_byte(tv[0].b[i], ok);
      chk($sformatf("midrst_byte%0d_accepted", i), ok, 1);
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_one_write_before", wr_addr.size(), 1);
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
